// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The operand source and result consumer sit on the master side; the adder is the slave.
interface pipelined_cla_adder_if #(
   parameter int unsigned WIDTH = 64
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with status flags.
// Stage 1 forms bit and group propagate/generate; stage 2 resolves carries and the result.
module pipelined_cla_adder #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned GROUP = 4
) (
   input logic                 clk,
   input logic                 rstn,
   pipelined_cla_adder_if.slave io
);
   localparam int unsigned NGRP = WIDTH / GROUP;

   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      logic [NGRP-1:0]  gp;
      logic [NGRP-1:0]  gg;
      logic             c0;
   } s1_t;

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             grp_run;
   s1_t              s1_d;
   s1_t              s1_q;
   logic             s1_valid;

   logic [NGRP:0]    gcar;
   logic [WIDTH:0]   car;
   logic             bit_c;
   logic [WIDTH-1:0] sum_d;

   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   // Global stall: the whole pipe advances only when the output slot can move.
   assign en          = ~out_valid_q | io.out_ready;
   assign io.in_ready = en;

   // Stage 1: effective operand, bit P/G and group GP/GG (no carry chain here).
   always_comb begin
      s1_d    = '0;
      grp_run = 1'b0;
      b_eff   = io.sub ? ~io.b : io.b;
      s1_d.p  = io.a ^ b_eff;
      s1_d.g  = io.a & b_eff;
      s1_d.c0 = io.sub | io.cin;
      for (int k = 0; k < NGRP; k++) begin
         grp_run     = 1'b0;
         s1_d.gp[k]  = &s1_d.p[k*GROUP +: GROUP];
         for (int j = 0; j < GROUP; j++) begin
            grp_run = s1_d.g[k*GROUP+j] | (s1_d.p[k*GROUP+j] & grp_run);
         end
         s1_d.gg[k]  = grp_run;
      end
   end

   // Stage 2: group carry chain, then in-group lookahead from each group carry-in.
   always_comb begin
      gcar    = '0;
      car     = '0;
      bit_c   = 1'b0;
      gcar[0] = s1_q.c0;
      for (int k = 0; k < NGRP; k++) begin
         gcar[k+1] = s1_q.gg[k] | (s1_q.gp[k] & gcar[k]);
      end
      for (int k = 0; k < NGRP; k++) begin
         bit_c = gcar[k];
         for (int j = 0; j < GROUP; j++) begin
            car[k*GROUP+j] = bit_c;
            bit_c          = s1_q.g[k*GROUP+j] | (s1_q.p[k*GROUP+j] & bit_c);
         end
      end
      car[WIDTH] = gcar[NGRP];
      sum_d      = s1_q.p ^ car[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q        <= '0;
         s1_valid    <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else if (en) begin
         s1_q        <= s1_d;
         s1_valid    <= io.in_valid;
         out_valid_q <= s1_valid;
         sum_q       <= sum_d;
         cout_q      <= car[WIDTH];
         ovf_q       <= car[WIDTH-1] ^ car[WIDTH];
         zero_q      <= ~|sum_d;
      end
   end

   assign io.out_valid = out_valid_q;
   assign io.sum       = sum_q;
   assign io.cout      = cout_q;
   assign io.ovf       = ovf_q;
   assign io.zero      = zero_q;
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, two-stage pipelined carry-lookahead adder/subtractor. It is the successor to the single-bit partial-full-adder cell: it generalises to WIDTH bits with GROUP-bit lookahead groups, adds a subtract mode and status flags, and registers results behind a valid/ready handshake. It is the arithmetic datapath slice of the 64-bit CLA, fed by an operand source and drained by a consumer that may apply backpressure.

## Interface
- WIDTH, 64: operand/result width; must be a multiple of GROUP.
- GROUP, 4: lookahead group width; legal values are 2, 4, 8.
- CLK  input  1  rising-edge clock.
- RSTN  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operand beat present.
- IN_READY  output  1  block accepts the beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in; ignored when SUB=1.
- SUB  input  1  0: A+B+CIN; 1: A-B, computed as A+~B+1.
- OUT_VALID  output  1  result beat present.
- OUT_READY  input  1  consumer accepts the result.
- SUM  output  WIDTH  result, modulo 2^WIDTH.
- COUT  output  1  carry out of the MSB. When SUB=1, COUT=1 means no borrow.
- OVF  output  1  two's-complement overflow: carry into MSB XOR COUT.
- ZERO  output  1  SUM == 0.

## Operation
- Effective operand: B' = SUB ? ~B : B. Effective carry-in: c0 = SUB ? 1 : CIN.
- Stage 1 (S1), registered on accept:
  - per-bit P = A^B' and G = A&B';
  - per-group GP = AND of the group's P bits;
  - per-group GG = G[n-1] | P[n-1]G[n-2] | ... | P[n-1]..P[1]G[0];
  - also stores c0 and an S1 valid bit.
- Stage 2 (S2), registered:
  - group carries c[k+1] = GG[k] | GP[k]&c[k], across WIDTH/GROUP groups;
  - in-group bit carries use lookahead from the group carry-in;
  - SUM = P ^ carries;
  - COUT = carry out of bit WIDTH-1;
  - OVF = carry into bit WIDTH-1 XOR COUT;
  - ZERO = ~|SUM.
- Flow control uses a global stall: en = ~OUT_VALID | OUT_READY.
  - IN_READY = en.
  - A beat is accepted when IN_VALID & IN_READY.
  - When en=1, S1 loads the incoming beat and IN_VALID sets S1 valid. S2 loads S1, and S2 valid takes S1 valid.
  - When en=0, every pipeline register holds its value.
- Stalled outputs: while OUT_VALID=1 and OUT_READY=0, SUM, COUT, OVF and ZERO stay stable.
- Bubbles in S1 are not squeezed out during a stall.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Reset (RSTN=0, asynchronous):
  - S1 valid, OUT_VALID, SUM, COUT, OVF and ZERO go to 0 immediately;
  - all S1 data registers go to 0;
  - in-flight beats are discarded;
  - IN_READY=1 while in reset, since it is combinational from OUT_VALID=0.

## Timing
- Latency: a beat accepted at edge N is presented with OUT_VALID=1 after edge N+1.
- Throughput: one result per cycle while OUT_READY=1.
- Accept and output in the same cycle: when en=1, both happen on the same edge and no beat is dropped.
- IN_READY and OUT_VALID have no combinational path from A, B, CIN or SUB. IN_READY depends combinationally only on OUT_VALID and OUT_READY.
- Critical path: S2 group-carry chain of WIDTH/GROUP AND-OR levels plus one in-group level. Stage 1 has no carry chain.
- Reset deassertion is assumed synchronised externally. On the first edge after release the pipeline is empty.

## Test plan
- Reset: hold RSTN=0 with IN_VALID=1 and random operands. Required: OUT_VALID=0, SUM=0, COUT=OVF=ZERO=0, IN_READY=1. After release and no input, OUT_VALID stays 0.
- Full ripple, WIDTH=64, SUB=0: A=FFFFFFFFFFFFFFFF, B=0, CIN=1. Two edges later: SUM=0, COUT=1, ZERO=1, OVF=0.
- Signed overflow: A=7FFFFFFFFFFFFFFF, B=1, CIN=0. Required: SUM=8000000000000000, OVF=1, COUT=0, ZERO=0.
- Subtract: SUB=1, A=5, B=7, CIN=1 (ignored). Required: SUM=FFFFFFFFFFFFFFFE, COUT=0, OVF=0. Then A=7, B=5: SUM=2, COUT=1.
- Backpressure: stream 1+1, 2+2, 3+3 back-to-back, and drop OUT_READY for 3 cycles while the first result is valid. Required:
  - SUM=2 holds stable for the 3 cycles;
  - IN_READY=0 during the stall;
  - after release, results appear in order 2, 4, 6, each exactly once.
- Mid-flight reset: accept two beats, then pulse RSTN low between edges. Required: OUT_VALID drops immediately and neither result ever appears. Repeat the sweep for GROUP=2 and 8 with WIDTH=16 against a reference A+B'+c0 on random vectors.
